// File: rtl/alu16.sv
`default_nettype none
// ============================================================================
//  Module   : alu16
//  Purpose  : 16-bit registered ALU (add/sub/logic/shift) with Z/C/N/V flags,
//             one result per cycle, latency 1.
//  Option   : define ALU16_SAT_EN to saturate ADD/SUB on signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
module alu16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [2:0]  select,
   input  logic        in_valid,
   output logic [15:0] ans,
   output logic        zero,
   output logic        carry,
   output logic        negative,
   output logic        overflow,
   output logic        out_valid
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOR = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   localparam logic [15:0] C_SAT_POS = 16'h7FFF;
   localparam logic [15:0] C_SAT_NEG = 16'h8000;

   op_e         op_w;
   logic [3:0]  sh_w;
   logic [16:0] sum_w;
   logic [16:0] diff_w;
   logic [16:0] shl_w;
   logic [16:0] shr_w;
   logic        add_ovf_w;
   logic        sub_ovf_w;

   logic [15:0] res_w;
   logic        carry_d;
   logic        ovf_d;
   logic [15:0] ans_d;

   logic [15:0] ans_q;
   logic        zero_q;
   logic        carry_q;
   logic        neg_q;
   logic        ovf_q;
   logic        valid_q;

   assign op_w   = op_e'(select);
   assign sh_w   = y[3:0];
   assign sum_w  = {1'b0, x} + {1'b0, y};
   assign diff_w = {1'b0, x} - {1'b0, y};
   // Extra bit catches the last bit shifted out; it is zero when sh_w == 0.
   assign shl_w  = {1'b0, x} << sh_w;
   assign shr_w  = {x, 1'b0} >> sh_w;

   assign add_ovf_w = (x[15] == y[15]) && (sum_w[15]  != x[15]);
   assign sub_ovf_w = (x[15] != y[15]) && (diff_w[15] != x[15]);

   always_comb begin
      res_w   = 16'h0000;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (op_w)
         OP_ADD: begin
            res_w   = sum_w[15:0];
            carry_d = sum_w[16];
            ovf_d   = add_ovf_w;
         end
         OP_SUB: begin
            res_w   = diff_w[15:0];
            carry_d = diff_w[16];
            ovf_d   = sub_ovf_w;
         end
         OP_AND: res_w = x & y;
         OP_OR:  res_w = x | y;
         OP_XOR: res_w = x ^ y;
         OP_NOR: res_w = ~(x | y);
         OP_SHL: begin
            res_w   = shl_w[15:0];
            carry_d = shl_w[16];
         end
         OP_SHR: begin
            res_w   = shr_w[16:1];
            carry_d = shr_w[0];
         end
         default: begin
            res_w   = 16'h0000;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      ans_d = res_w;
`ifdef ALU16_SAT_EN
      // Clamp toward the sign of x; carry keeps the unsaturated value.
      if (((op_w == OP_ADD) || (op_w == OP_SUB)) && ovf_d)
         ans_d = x[15] ? C_SAT_NEG : C_SAT_POS;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ans_q   <= 16'h0000;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            ans_q   <= ans_d;
            zero_q  <= (ans_d == 16'h0000);
            carry_q <= carry_d;
            neg_q   <= ans_d[15];
            ovf_q   <= ovf_d;
         end
      end
   end

   assign ans       = ans_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign negative  = neg_q;
   assign overflow  = ovf_q;
   assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu16
//  Purpose  : randomized self-checking bench for alu16 against an arithmetic
//             reference model (honours ALU16_SAT_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu16;

   logic        clk;
   logic        rst;
   logic [15:0] x;
   logic [15:0] y;
   logic [2:0]  select;
   logic        in_valid;
   logic [15:0] ans;
   logic        zero, carry, negative, overflow, out_valid;

   alu16 dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .select(select), .in_valid(in_valid),
      .ans(ans), .zero(zero), .carry(carry), .negative(negative),
      .overflow(overflow), .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: what the outputs should show after the next edge.
   int m_ans = 0;
   bit m_z = 0, m_c = 0, m_n = 0, m_v = 0, m_ov = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model_op(input int a, input int b, input int op,
                           output int r, output bit c, output bit v);
      int sa, sb, ss, sh;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      sh = b % 16;
      c = 0; v = 0; ss = 0;
      case (op)
         0: begin r = (a + b) % 65536; c = (a + b) >= 65536;
                  ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
         1: begin r = (a - b + 65536) % 65536; c = a < b;
                  ss = sa - sb; v = (ss > 32767) || (ss < -32768); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 65535 - (a | b);
         6: begin r = (a * (1 << sh)) % 65536;
                  c = (sh != 0) && (((a >> (16 - sh)) & 1) == 1); end
         default: begin r = a / (1 << sh);
                  c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      endcase
`ifdef ALU16_SAT_EN
      if (v) r = (ss > 0) ? 32767 : 32768;
`endif
   endtask

   task automatic step(input bit r, input bit iv, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] op, input string tag);
      int res; bit c, v;
      @(negedge clk);
      rst = r; in_valid = iv; x = a; y = b; select = op;
      if (r) begin
         m_ans = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_ov = 0;
      end else begin
         m_ov = iv;
         if (iv) begin
            model_op(int'(a), int'(b), int'(op), res, c, v);
            m_ans = res; m_c = c; m_v = v;
            m_z = (res == 0); m_n = (res >= 32768);
         end
      end
      @(posedge clk);
      #1;
      check({tag, ".ans"}, {16'h0, ans}, m_ans[31:0]);
      check({tag, ".flags"}, {27'h0, zero, carry, negative, overflow, out_valid},
            {27'h0, m_z, m_c, m_n, m_v, m_ov});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; select = '0;

      // Reset with in_valid asserted: reset must win.
      step(1, 1, 16'hFFFF, 16'h0001, 3'd0, "reset0");
      step(1, 0, 16'h0000, 16'h0000, 3'd0, "reset1");

      // Directed cases, with independent constant checks on key results.
      step(0, 1, 16'h5555, 16'hAAAA, 3'd0, "add55");
      check("add55.const", {16'h0, ans, zero, carry, negative, overflow},
            {16'h0, 16'hFFFF, 4'b0010});
      step(0, 1, 16'h5555, 16'hAAAA, 3'd1, "sub55");
      check("sub55.const", {16'h0, ans, zero, carry, negative, overflow},
            {16'h0, 16'hAAAB, 4'b0111});
      step(0, 1, 16'h5555, 16'hAAAA, 3'd2, "and55");
      step(0, 1, 16'h5555, 16'hAAAA, 3'd3, "or55");
      step(0, 1, 16'h5555, 16'hAAAA, 3'd4, "xor55");
      step(0, 1, 16'h5555, 16'hAAAA, 3'd5, "nor55");
      step(0, 1, 16'h5555, 16'hAAAA, 3'd6, "shl10");
      check("shl10.const", {15'h0, ans, carry}, {15'h0, 16'h5400, 1'b1});
      step(0, 1, 16'h5555, 16'hAAAA, 3'd7, "shr10");
      check("shr10.const", {15'h0, ans, carry}, {15'h0, 16'h0015, 1'b0});
      step(0, 1, 16'h8001, 16'hFFF0, 3'd6, "shl0");
      step(0, 1, 16'h8001, 16'hFFF0, 3'd7, "shr0");
      step(0, 1, 16'h8001, 16'h000F, 3'd6, "shl15");
      step(0, 1, 16'h8001, 16'h000F, 3'd7, "shr15");
      step(0, 1, 16'h7FFF, 16'h0001, 3'd0, "addovf");
`ifdef ALU16_SAT_EN
      check("addovf.const", {16'h0, ans, overflow, negative}, {16'h0, 16'h7FFF, 2'b10});
`else
      check("addovf.const", {16'h0, ans, overflow, negative}, {16'h0, 16'h8000, 2'b11});
`endif
      step(0, 1, 16'h8000, 16'h0001, 3'd1, "subovf");
      step(0, 1, 16'hFFFF, 16'h0001, 3'd0, "addwrap");
      step(0, 1, 16'h0000, 16'h0001, 3'd1, "subborrow");
      step(0, 0, 16'h1234, 16'h4321, 3'd0, "hold0");
      step(0, 0, 16'hFFFF, 16'hFFFF, 3'd5, "hold1");

      // Reset in the middle of a stream of valid ops.
      step(0, 1, 16'h1234, 16'h0FF0, 3'd0, "pre_rst");
      step(1, 1, 16'h7FFF, 16'h7FFF, 3'd0, "mid_rst");
      step(0, 0, 16'h7FFF, 16'h7FFF, 3'd0, "post_rst");

      for (int i = 0; i < 400; i++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = 16'($urandom);
         // Bias some operands toward the sign/carry boundaries.
         if ($urandom_range(0, 7) == 0) a = {a[15], {15{~a[15]}}};
         if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(0, 2));
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
              a, b, 3'($urandom_range(0, 7)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
